pe_arr_ctrl: RTL and testbench
==============================

PE_ARR_CTRL -- requirements
Module: pe_arr_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8: input feature map width in pixels, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 8: input feature map height in pixels, minimum 3.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: width of the buffer address buses.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a 3x3 stride-1 convolution pass.
REQ-007 SHALL have port abort, input, 1: cancels the current pass.
REQ-008 SHALL have port ifm_base, input, ADDR_WIDTH: IFM buffer base address, sampled on accepted start.
REQ-009 SHALL have port ofm_base, input, ADDR_WIDTH: OFM buffer base address, sampled on accepted start.
REQ-010 SHALL have port ifm_rd_en / ifm_rd_addr, output, 1 / ADDR_WIDTH: IFM row-segment read strobe and address.
REQ-011 SHALL have port ready_load, output, 1: one-cycle launch pulse to the PE array.
REQ-012 SHALL have port ready_activation, input, 1: PE array result-valid pulse.
REQ-013 SHALL have port ofm_wr_en / ofm_wr_addr, output, 1 / ADDR_WIDTH: OFM result write strobe and address.
REQ-014 SHALL have port busy, output, 1: high from the cycle after accepted start until return to IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, WRITE, FIN.
REQ-017 IDLE: start=1 SHALL latch ifm_base/ofm_base, clear row/col to 0, and enter FETCH; start SHALL be ignored in all other states.
REQ-018 FETCH SHALL last exactly 3 cycles with ifm_rd_en=1, ifm_rd_addr = ifm_base + (row+r)*IMG_W + col for r = 0,1,2.
REQ-019 ISSUE SHALL last 1 cycle with ready_load=1, then enter WAIT.
REQ-020 WAIT SHALL hold until ready_activation=1, then enter WRITE; there is no timeout.
REQ-021 ready_activation SHALL be ignored outside WAIT.
REQ-022 WRITE SHALL last 1 cycle with ofm_wr_en=1, ofm_wr_addr = ofm_base + row*(IMG_W-2) + col.
REQ-023 After WRITE: if col < IMG_W-3, col SHALL increment; else col SHALL reset to 0 and row SHALL increment.
REQ-024 After WRITE, the FSM SHALL enter FETCH, or FIN after the write at row=IMG_H-3, col=IMG_W-3.
REQ-025 FIN SHALL last 1 cycle with done=1, then enter IDLE.
REQ-026 Total writes per pass SHALL be (IMG_W-2)*(IMG_H-2), in raster order.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and no further strobes.
REQ-029 abort SHALL take priority over ready_activation in the same cycle.
REQ-030 Outputs SHALL be registered; ifm_rd_en, ready_load, ofm_wr_en and done SHALL be mutually exclusive.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, row=col=0, and every output to 0, including any mid-pass state.
REQ-032 After rst_n release, the first start SHALL begin a clean pass.

Configuration
REQ-033 With PE_CTRL_PERF_CNT_EN defined, the block SHALL add output perf_cycles[31:0]: cleared on accepted start, incremented each cycle while busy=1, held otherwise, saturating at 2^32-1, reset to 0.
REQ-034 Without PE_CTRL_PERF_CNT_EN, perf_cycles and its logic SHALL be absent.

Verification
REQ-035 Scenario: IMG_W=IMG_H=4, ifm_base=0, ofm_base=0x100, ready_activation 2 cycles after each ready_load -> FETCH addrs 0,4,8 for first window; 4 writes at 0x100..0x103; one done pulse.
REQ-036 Scenario: IMG_W=IMG_H=8 -> exactly 36 ofm_wr_en pulses; last addr = ofm_base+35; first-row reads of window (5,5) = 45,53,61.
REQ-037 Scenario: start pulsed in WAIT -> ignored; latched bases unchanged; write count unaffected.
REQ-038 Scenario: abort in WAIT coincident with ready_activation -> IDLE next cycle; no ofm_wr_en; no done.
REQ-039 Scenario: rst_n low during FETCH -> all outputs 0 immediately; a subsequent start produces a full correct pass.
REQ-040 Scenario: PE_CTRL_PERF_CNT_EN defined, IMG_W=IMG_H=4, fixed 2-cycle array latency -> perf_cycles equals the counted busy cycles (FETCH 3 + ISSUE 1 + WAIT 2 + WRITE 1 per window, plus FIN) and holds after done.

Source files
------------

// File: rtl/pe_arr_ctrl.sv
// Sequencer for a 3x3 stride-1 convolution pass over an IMG_W x IMG_H feature map.
// Optional cycle counter output perf_cycles is enabled by defining PE_CTRL_PERF_CNT_EN.
module pe_arr_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] ifm_base,
  input  logic [ADDR_WIDTH-1:0] ofm_base,
  output logic                  ifm_rd_en,
  output logic [ADDR_WIDTH-1:0] ifm_rd_addr,
  output logic                  ready_load,
  input  logic                  ready_activation,
  output logic                  ofm_wr_en,
  output logic [ADDR_WIDTH-1:0] ofm_wr_addr,
  output logic                  busy,
  output logic                  done
`ifdef PE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
  localparam logic [ADDR_WIDTH-1:0] IFM_STRIDE = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] OFM_STRIDE = ADDR_WIDTH'(IMG_W - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [1:0]              rsel_q, rsel_d;
  logic [ADDR_WIDTH-1:0]   ifm_base_q, ifm_base_d;
  logic [ADDR_WIDTH-1:0]   ofm_base_q, ofm_base_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_d, wr_addr_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rsel_d     = rsel_q;
    ifm_base_d = ifm_base_q;
    ofm_base_d = ofm_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ifm_base_d = ifm_base;
          ofm_base_d = ofm_base;
          row_d      = '0;
          col_d      = '0;
          rsel_d     = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rsel_q == 2'd2) begin
          rsel_d  = '0;
          state_d = S_ISSUE;
        end else begin
          rsel_d = rsel_q + 2'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ready_activation) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (row_q == LAST_ROW && col_q == LAST_COL) begin
          state_d = S_FIN;
        end else begin
          state_d = S_FETCH;
          if (col_q < LAST_COL) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every other transition, including a coincident result pulse.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      rsel_d  = '0;
    end
  end

  // Addresses are built from next-state values so the registered outputs line up with the state.
  always_comb begin
    rd_addr_d = ifm_base_d + (ADDR_WIDTH'(row_d) + ADDR_WIDTH'(rsel_d)) * IFM_STRIDE
                + ADDR_WIDTH'(col_d);
    wr_addr_d = ofm_base_d + ADDR_WIDTH'(row_d) * OFM_STRIDE + ADDR_WIDTH'(col_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      rsel_q     <= '0;
      ifm_base_q <= '0;
      ofm_base_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rsel_q     <= rsel_d;
      ifm_base_q <= ifm_base_d;
      ofm_base_q <= ofm_base_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_rd_en   <= 1'b0;
      ifm_rd_addr <= '0;
      ready_load  <= 1'b0;
      ofm_wr_en   <= 1'b0;
      ofm_wr_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ifm_rd_en   <= (state_d == S_FETCH);
      ifm_rd_addr <= (state_d == S_FETCH) ? rd_addr_d : '0;
      ready_load  <= (state_d == S_ISSUE);
      ofm_wr_en   <= (state_d == S_WRITE);
      ofm_wr_addr <= (state_d == S_WRITE) ? wr_addr_d : '0;
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_FIN);
    end
  end

`ifdef PE_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  // Counts cycles with busy high, restarting on each accepted start and saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_q <= '0;
    end else if (busy && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pe_arr_ctrl.sv
// Directed bench for pe_arr_ctrl: a 4x4 instance for cycle-exact vectors and corner cases,
// and a default 8x8 instance for the full-frame pass.
module tb_pe_arr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ract, sel;
  logic [11:0] ifmBase, ofmBase;

  logic        rdEn4, load4, wrEn4, busy4, done4;
  logic [11:0] rdAddr4, wrAddr4;
  logic        rdEn8, load8, wrEn8, busy8, done8;
  logic [11:0] rdAddr8, wrAddr8;
`ifdef PE_CTRL_PERF_CNT_EN
  logic [31:0] perf4, perf8;
`endif

  logic        obsRdEn, obsLoad, obsWrEn, obsBusy, obsDone;
  logic [11:0] obsRdAddr, obsWrAddr;

  always #5 clk = ~clk;

  pe_arr_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_WIDTH(12)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
    .ifm_base(ifmBase), .ofm_base(ofmBase),
    .ifm_rd_en(rdEn4), .ifm_rd_addr(rdAddr4), .ready_load(load4),
    .ready_activation(ract & ~sel), .ofm_wr_en(wrEn4), .ofm_wr_addr(wrAddr4),
    .busy(busy4), .done(done4)
`ifdef PE_CTRL_PERF_CNT_EN
    , .perf_cycles(perf4)
`endif
  );

  pe_arr_ctrl #(.IMG_W(8), .IMG_H(8), .ADDR_WIDTH(12)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
    .ifm_base(ifmBase), .ofm_base(ofmBase),
    .ifm_rd_en(rdEn8), .ifm_rd_addr(rdAddr8), .ready_load(load8),
    .ready_activation(ract & sel), .ofm_wr_en(wrEn8), .ofm_wr_addr(wrAddr8),
    .busy(busy8), .done(done8)
`ifdef PE_CTRL_PERF_CNT_EN
    , .perf_cycles(perf8)
`endif
  );

  assign obsRdEn   = sel ? rdEn8   : rdEn4;
  assign obsRdAddr = sel ? rdAddr8 : rdAddr4;
  assign obsLoad   = sel ? load8   : load4;
  assign obsWrEn   = sel ? wrEn8   : wrEn4;
  assign obsWrAddr = sel ? wrAddr8 : wrAddr4;
  assign obsBusy   = sel ? busy8   : busy4;
  assign obsDone   = sel ? done8   : done4;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ract;
    logic        rdEn;
    logic [11:0] rdAddr;
    logic        load;
    logic        wrEn;
    logic [11:0] wrAddr;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  int          numChecks = 0;
  int          numFail = 0;
  int          nDone;
  bit          exclBad, timedOut;
  logic [11:0] wrQ[$];
  logic [11:0] rdQ[$];

  function automatic void addVec(input logic st, input logic ab, input logic ra,
                                 input logic re, input logic [11:0] ra2, input logic ld,
                                 input logic we, input logic [11:0] wa, input logic bz,
                                 input logic dn);
    vec_t v;
    v.start = st; v.abort = ab; v.ract = ra;
    v.rdEn = re; v.rdAddr = ra2; v.load = ld;
    v.wrEn = we; v.wrAddr = wa; v.busy = bz; v.done = dn;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start;
    abort = v.abort;
    ract  = v.ract;
    @(posedge clk);
    #1;
  endtask

  // Runs one pass on the selected instance with a 2-cycle array latency, logging every strobe.
  task automatic runPass(input logic [11:0] ib, input logic [11:0] ob, input bit injStart);
    int cnt;
    bit inj;
    cnt = 0; inj = injStart;
    wrQ.delete(); rdQ.delete();
    nDone = 0; exclBad = 0; timedOut = 1;
    ifmBase = ib; ofmBase = ob; abort = 0; ract = 0; start = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2000; c++) begin
      start = 0;
      ract  = 0;
      if (obsRdEn) rdQ.push_back(obsRdAddr);
      if (obsWrEn) wrQ.push_back(obsWrAddr);
      if (obsDone) nDone++;
      if (int'(obsRdEn) + int'(obsLoad) + int'(obsWrEn) + int'(obsDone) > 1) exclBad = 1;
      if (!obsBusy) begin
        timedOut = 0;
        break;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 1 && inj) begin
          start   = 1;
          ifmBase = 12'hABC;
          ofmBase = 12'hDEF;
          inj     = 0;
        end
        if (cnt == 0) ract = 1;
      end
      if (obsLoad) cnt = 2;
      @(posedge clk);
      #1;
    end
    start = 0;
    ract  = 0;
  endtask

  initial begin
    int bad;
    int strobes;
    sel = 0; rst_n = 0; start = 0; abort = 0; ract = 0;
    ifmBase = 12'h000; ofmBase = 12'h100;

    // Cycle-exact 4x4 pass: three fetches, issue, two wait cycles, write per window.
    addVec(0, 0, 1, 0, 12'h000, 0, 0, 12'h000, 0, 0);
    addVec(0, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0);
    for (int row = 0; row < 2; row++) begin
      for (int col = 0; col < 2; col++) begin
        for (int r = 0; r < 3; r++) begin
          addVec((row == 0 && col == 0 && r == 0), 0, 0,
                 1, 12'((row + r) * 4 + col), 0, 0, 12'h000, 1, 0);
        end
        addVec(0, 0, 0, 0, 12'h000, 1, 0, 12'h000, 1, 0);
        addVec(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0);
        addVec(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0);
        addVec(0, 0, 1, 0, 12'h000, 0, 1, 12'(12'h100 + row * 2 + col), 1, 0);
      end
    end
    addVec(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1);
    addVec(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0);
    addVec(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState4", 64'({rdEn4, rdAddr4, load4, wrEn4, wrAddr4, busy4, done4}), 64'd0);
    checkOutput("resetState8", 64'({rdEn8, rdAddr8, load8, wrEn8, wrAddr8, busy8, done8}), 64'd0);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i),
                  64'({obsRdEn, obsRdAddr, obsLoad, obsWrEn, obsWrAddr, obsBusy, obsDone}),
                  64'({vecs[i].rdEn, vecs[i].rdAddr, vecs[i].load, vecs[i].wrEn,
                       vecs[i].wrAddr, vecs[i].busy, vecs[i].done}));
    end
`ifdef PE_CTRL_PERF_CNT_EN
    checkOutput("perfCycles", 64'(perf4), 64'd29);
    @(posedge clk);
    #1;
    checkOutput("perfHold", 64'(perf4), 64'd29);
`endif

    // Start pulsed while waiting must not re-latch bases or restart the pass.
    runPass(12'h010, 12'h200, 1);
    checkOutput("injTimeout", 64'(timedOut), 64'd0);
    checkOutput("injWrites", 64'(wrQ.size()), 64'd4);
    bad = 0;
    for (int i = 0; i < wrQ.size(); i++) if (wrQ[i] !== 12'(12'h200 + i)) bad++;
    checkOutput("injWrAddrs", 64'(bad), 64'd0);
    checkOutput("injReads", 64'(rdQ.size()), 64'd12);
    if (rdQ.size() == 12) begin
      checkOutput("injFirstRd", 64'({rdQ[0], rdQ[1], rdQ[2]}), 64'({12'h010, 12'h014, 12'h018}));
      checkOutput("injLastRd", 64'({rdQ[9], rdQ[10], rdQ[11]}), 64'({12'h015, 12'h019, 12'h01D}));
    end
    checkOutput("injDone", 64'(nDone), 64'd1);
    checkOutput("injExclusive", 64'(exclBad), 64'd0);

    // Abort in WAIT coincident with the result pulse returns straight to idle.
    ifmBase = 12'h000; ofmBase = 12'h100; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    for (int c = 0; c < 20 && !obsLoad; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abortSawLoad", 64'(obsLoad), 64'd1);
    @(posedge clk);
    #1;
    abort = 1; ract = 1;
    @(posedge clk);
    #1;
    checkOutput("abortIdle", 64'({obsBusy, obsRdEn, obsLoad, obsWrEn, obsDone}), 64'd0);
    abort = 0; ract = 0;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      strobes += int'(obsRdEn) + int'(obsLoad) + int'(obsWrEn) + int'(obsDone) + int'(obsBusy);
    end
    checkOutput("abortQuiet", 64'(strobes), 64'd0);

    // Reset asserted mid-fetch clears outputs without waiting for a clock edge.
    ifmBase = 12'h000; ofmBase = 12'h100; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    checkOutput("rstFetching", 64'(obsRdEn), 64'd1);
    #2;
    rst_n = 0;
    #1;
    checkOutput("rstAsync", 64'({obsRdEn, obsRdAddr, obsLoad, obsWrEn, obsWrAddr, obsBusy, obsDone}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    runPass(12'h000, 12'h100, 0);
    checkOutput("rstPassTimeout", 64'(timedOut), 64'd0);
    checkOutput("rstPassWrites", 64'(wrQ.size()), 64'd4);
    bad = 0;
    for (int i = 0; i < wrQ.size(); i++) if (wrQ[i] !== 12'(12'h100 + i)) bad++;
    checkOutput("rstPassAddrs", 64'(bad), 64'd0);
    checkOutput("rstPassDone", 64'(nDone), 64'd1);

    // Full 8x8 frame with the output base chosen so addresses wrap past 0xFFF.
    sel = 1;
    runPass(12'h000, 12'hFF0, 0);
    checkOutput("frame8Timeout", 64'(timedOut), 64'd0);
    checkOutput("frame8Writes", 64'(wrQ.size()), 64'd36);
    bad = 0;
    for (int i = 0; i < wrQ.size(); i++) if (wrQ[i] !== 12'(12'hFF0 + i)) bad++;
    checkOutput("frame8Raster", 64'(bad), 64'd0);
    if (wrQ.size() == 36) checkOutput("frame8LastWr", 64'(wrQ[35]), 64'h013);
    checkOutput("frame8Reads", 64'(rdQ.size()), 64'd108);
    if (rdQ.size() == 108)
      checkOutput("frame8Win55", 64'({rdQ[105], rdQ[106], rdQ[107]}), 64'({12'd45, 12'd53, 12'd61}));
    checkOutput("frame8Done", 64'(nDone), 64'd1);
    checkOutput("frame8Exclusive", 64'(exclBad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFail);
    $finish;
  end

endmodule
